// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : IF stage of a 5-stage MIPS pipeline. Holds the PC and a
//                word-addressed instruction memory, and registers
//                {instruction, PC+4} into the IF/ID register. Supports stall,
//                flush, branch/jump redirect, a program-load write port and
//                sticky HALT detection.
//                Optional macro IF_DEBUG_STEP_EN adds single-step ports
//                (i_step_mode, i_step).
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int              SIZE      = 32,
  parameter int              MEM_DEPTH = 256,
  parameter int              ADDR_BITS = $clog2(MEM_DEPTH),
  parameter logic [SIZE-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_pc_src,
  input  logic [SIZE-1:0]      i_jump_addr,
  input  logic                 i_mem_we,
  input  logic [ADDR_BITS-1:0] i_mem_addr,
  input  logic [SIZE-1:0]      i_mem_data,
`ifdef IF_DEBUG_STEP_EN
  input  logic                 i_step_mode,
  input  logic                 i_step,
`endif
  output logic [SIZE-1:0]      o_instruction,
  output logic [SIZE-1:0]      o_pc_plus4,
  output logic [SIZE-1:0]      o_pc,
  output logic                 o_halt
);

  localparam logic [SIZE-1:0] PC_STEP = SIZE'(4);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Instruction memory (not reset; loaded through the write port)
  logic [SIZE-1:0] mem_q [MEM_DEPTH];

  state_t          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] instr_q, instr_d;
  logic [SIZE-1:0] pc4_q, pc4_d;

  logic            w_hold;
  logic [SIZE-1:0] w_fetch_word;
  logic [SIZE-1:0] w_pc_plus4;

  // Single-step mode freezes the stage exactly like a hazard stall
`ifdef IF_DEBUG_STEP_EN
  assign w_hold = i_stall | (i_step_mode & ~i_step);
`else
  assign w_hold = i_stall;
`endif

  // pc[1:0] is ignored; the word index wraps modulo the memory depth
  assign w_fetch_word = mem_q[pc_q[ADDR_BITS+1:2]];
  assign w_pc_plus4   = pc_q + PC_STEP;

  // Program-load port: writes land on the edge, so a same-cycle fetch sees old data
  always_ff @(posedge clk) begin
    if (i_mem_we) begin
      mem_q[i_mem_addr] <= i_mem_data;
    end
  end

  // Next-state selection: stall > halted > normal fetch/redirect
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (!w_hold) begin
      case (state_q)
        ST_HALTED: begin
          // PC is frozen; only a flush may still clear IF/ID
          if (i_flush) begin
            instr_d = '0;
            pc4_d   = '0;
          end
        end
        default: begin
          if (w_fetch_word == HALT_WORD) begin
            // Latch the HALT word and freeze the PC (no increment, no redirect)
            state_d = ST_HALTED;
            instr_d = i_flush ? '0 : w_fetch_word;
            pc4_d   = i_flush ? '0 : w_pc_plus4;
          end else begin
            pc_d    = i_pc_src ? i_jump_addr : w_pc_plus4;
            instr_d = i_flush ? '0 : w_fetch_word;
            pc4_d   = i_flush ? '0 : w_pc_plus4;
          end
        end
      endcase
    end
  end

  // PC, IF/ID register and RUN/HALTED state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc_plus4    = pc4_q;
  assign o_pc          = pc_q;
  assign o_halt        = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch. A behavioural
//                model predicts IF/ID, PC and halt per edge; predictions are
//                queued when stimulus is driven and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall, i_flush, i_pc_src, i_mem_we;
  logic [31:0] i_jump_addr, i_mem_data;
  logic [7:0]  i_mem_addr;
  logic        i_step_mode, i_step;
  logic [31:0] o_instruction, o_pc_plus4, o_pc;
  logic        o_halt;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        halt;
  } exp_t;
  exp_t sb_q[$];

  // Behavioural model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_ir, m_pc4;
  logic        m_halt;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_pc_src     (i_pc_src),
    .i_jump_addr  (i_jump_addr),
    .i_mem_we     (i_mem_we),
    .i_mem_addr   (i_mem_addr),
    .i_mem_data   (i_mem_data),
`ifdef IF_DEBUG_STEP_EN
    .i_step_mode  (i_step_mode),
    .i_step       (i_step),
`endif
    .o_instruction(o_instruction),
    .o_pc_plus4   (o_pc_plus4),
    .o_pc         (o_pc),
    .o_halt       (o_halt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    pat = 32'h2000_0000 + (32'(i + 1) << 16) + 32'(i + 1);
  endfunction

  // Predict the next edge from the current inputs, then compare after it
  task automatic cycle();
    exp_t        e, got;
    logic [31:0] f, np;
    logic        hold;
    f    = m_mem[m_pc[9:2]];
    np   = m_pc + 32'd4;
    hold = i_stall | (i_step_mode & ~i_step);
    if (rst && !hold) begin
      if (m_halt) begin
        if (i_flush) begin m_ir = 0; m_pc4 = 0; end
      end else if (f == HALT) begin
        m_halt = 1'b1;
        m_ir   = i_flush ? 32'd0 : f;
        m_pc4  = i_flush ? 32'd0 : np;
      end else begin
        m_ir  = i_flush ? 32'd0 : f;
        m_pc4 = i_flush ? 32'd0 : np;
        m_pc  = i_pc_src ? i_jump_addr : np;
      end
    end
    if (i_mem_we) m_mem[i_mem_addr] = i_mem_data;
    e.ir = m_ir; e.pc4 = m_pc4; e.pc = m_pc; e.halt = m_halt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sb_instr", o_instruction, got.ir);
    check("sb_pc4",   o_pc_plus4,    got.pc4);
    check("sb_pc",    o_pc,          got.pc);
    check("sb_halt",  {31'd0, o_halt}, {31'd0, got.halt});
  endtask

  task automatic go(input logic st, input logic fl, input logic src, input logic [31:0] ja,
                    input logic we, input logic [7:0] wa, input logic [31:0] wd);
    i_stall = st; i_flush = fl; i_pc_src = src; i_jump_addr = ja;
    i_mem_we = we; i_mem_addr = wa; i_mem_data = wd;
    cycle();
  endtask

  task automatic idle();
    go(0, 0, 0, 0, 0, 8'd0, 0);
  endtask

  initial begin
    rst = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_stall = 0; i_flush = 0; i_pc_src = 0; i_jump_addr = 0;
    i_mem_we = 0; i_mem_addr = 0; i_mem_data = 0;
    m_pc = 0; m_ir = 0; m_pc4 = 0; m_halt = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;

    // Load program while in reset
    for (int i = 0; i < 256; i++) go(0, 0, 0, 0, 1, 8'(i), pat(i));
    check("rst_instr", o_instruction, 32'd0);
    check("rst_pc", o_pc, 32'd0);

    // Sequential fetch
    rst = 1'b1;
    idle();
    check("seq1_instr", o_instruction, 32'h20010001);
    check("seq1_pc4", o_pc_plus4, 32'd4);
    check("seq1_pc", o_pc, 32'd4);
    idle();
    check("seq2_instr", o_instruction, 32'h20020002);
    check("seq2_pc", o_pc, 32'd8);

    // Stall holds PC and IF/ID
    for (int i = 0; i < 3; i++) begin
      go(1, 0, 0, 0, 0, 8'd0, 0);
      check("stall_instr", o_instruction, 32'h20020002);
      check("stall_pc4", o_pc_plus4, 32'd8);
      check("stall_pc", o_pc, 32'd8);
    end
    idle();
    check("resume_instr", o_instruction, 32'h20030003);
    idle();
    check("seq4_instr", o_instruction, 32'h20040004);
    check("seq4_pc", o_pc, 32'd16);

    // Redirect + flush
    go(0, 1, 1, 32'h40, 0, 8'd0, 0);
    check("flush_instr", o_instruction, 32'd0);
    check("flush_pc4", o_pc_plus4, 32'd0);
    check("redir_pc", o_pc, 32'h40);
    idle();
    check("target_instr", o_instruction, 32'h20110011);

    // Stall beats redirect
    for (int i = 0; i < 2; i++) begin
      go(1, 0, 1, 32'h80, 0, 8'd0, 0);
      check("stallprio_pc", o_pc, 32'h44);
    end
    go(0, 0, 1, 32'h80, 0, 8'd0, 0);
    check("stallrel_pc", o_pc, 32'h80);

    // Index wrap and same-cycle write
    go(0, 0, 1, 32'd1024, 0, 8'd0, 0);
    check("wrap_pc", o_pc, 32'd1024);
    go(0, 0, 1, 32'd1024, 1, 8'd0, 32'hDEADBEEF);
    check("wr_old_instr", o_instruction, 32'h20010001);
    idle();
    check("wr_new_instr", o_instruction, 32'hDEADBEEF);
    check("wr_new_pc4", o_pc_plus4, 32'd1028);

    // PC wraps mod 2^32
    go(0, 0, 1, 32'hFFFFFFFC, 0, 8'd0, 0);
    idle();
    check("pcwrap_instr", o_instruction, 32'h21000100);
    check("pcwrap_pc4", o_pc_plus4, 32'd0);
    check("pcwrap_pc", o_pc, 32'd0);

    // Halt
    go(0, 0, 0, 0, 1, 8'd2, HALT);
    idle();
    idle();
    check("halt_flag", {31'd0, o_halt}, 32'd1);
    check("halt_instr", o_instruction, HALT);
    check("halt_pc", o_pc, 32'd8);
    for (int i = 0; i < 3; i++) go(0, 0, 1, 32'h200, 0, 8'd0, 0);
    check("halt_hold_pc", o_pc, 32'd8);
    go(0, 1, 0, 0, 0, 8'd0, 0);
    check("halt_flush_instr", o_instruction, 32'd0);

    // Asynchronous reset mid-cycle
    rst = 1'b0;
    #2;
    check("arst_halt", {31'd0, o_halt}, 32'd0);
    check("arst_pc", o_pc, 32'd0);
    m_pc = 0; m_ir = 0; m_pc4 = 0; m_halt = 0;
    idle();
    rst = 1'b1;

`ifdef IF_DEBUG_STEP_EN
    i_step_mode = 1'b1;
    idle();
    idle();
    check("step_hold_pc", o_pc, 32'd0);
    i_step = 1'b1;
    idle();
    check("step_adv_pc", o_pc, 32'd4);
    i_step_mode = 1'b0; i_step = 1'b0;
`endif

    for (int i = 0; i < 6; i++) idle();
    check("rehalt_flag", {31'd0, o_halt}, 32'd1);
    check("rehalt_pc", o_pc, 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of instruction decode. Holds the PC and a word-addressed instruction memory. Registers {instruction, PC+4} into the IF/ID pipeline register that decode consumes. Supports stall, flush, branch/jump redirect, a program-load write port and HALT detection.

Parameters:
SIZE, 32, data/address width in bits
MEM_DEPTH, 256, instruction memory depth in words
ADDR_BITS, $clog2(MEM_DEPTH), word-index width
HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
i_stall  input  1  hold PC and IF/ID (hazard unit)
i_flush  input  1  load NOP (0) into IF/ID
i_pc_src  input  1  select i_jump_addr as next PC
i_jump_addr  input  SIZE  branch/jump target, byte address
i_mem_we  input  1  instruction memory write enable
i_mem_addr  input  ADDR_BITS  write word index
i_mem_data  input  SIZE  write data
o_instruction  output  SIZE  IF/ID instruction, to decode
o_pc_plus4  output  SIZE  IF/ID PC+4, to decode
o_pc  output  SIZE  current PC (debug)
o_halt  output  1  HALT fetched, sticky

Behaviour:
- Reset (rst=0, asynchronous): pc=0, o_instruction=0, o_pc_plus4=0, o_halt=0. Memory contents are not reset.
- Fetch: the memory read is combinational at word index pc[ADDR_BITS+1:2]; pc[1:0] is ignored.
- Indices wrap modulo MEM_DEPTH. The PC itself wraps mod 2^SIZE (0xFFFFFFFC+4 -> 0).
- Latency: the instruction at PC appears on o_instruction one edge after the PC holds that address. o_pc_plus4 = that PC+4.
- Per edge, priority high to low:
  1. Stall: i_stall=1 -> pc and IF/ID hold; i_flush and i_pc_src are ignored. The source must keep them asserted.
  2. Halted: o_halt=1 -> pc holds, IF/ID holds the HALT word; i_pc_src is ignored. i_flush still loads 0 into IF/ID.
  3. Otherwise: pc <= i_pc_src ? i_jump_addr : pc+4. IF/ID <= i_flush ? {0,0} : {mem[pc], pc+4}.
- Halt: when not stalled and mem[pc]==HALT_WORD, on that edge:
  - IF/ID latches the HALT word;
  - o_halt <= 1;
  - pc holds (no increment, no redirect).
  - o_halt clears only on reset.
- Flush and redirect in the same cycle: PC takes the target and IF/ID gets the NOP. This is the branch-taken case.
- Memory write: synchronous on clk when i_mem_we=1, accepted in any state, including stall and halt.
  - A write to the word being fetched in the same cycle: IF/ID captures the old data; the new data is visible next cycle.
- States: RUN, HALTED (o_halt). RUN -> HALTED on HALT fetch; HALTED -> RUN only via reset.

Optional Feature:
Macro IF_DEBUG_STEP_EN.
- Defined: adds inputs i_step_mode (1) and i_step (1).
  - With i_step_mode=1, the PC and IF/ID advance only on edges where i_step=1; other edges behave as i_stall=1.
  - i_step_mode=0 gives normal operation.
  - Halt and memory-write rules are unchanged.
- Not defined: the ports do not exist and fetch free-runs as described above.

Test Plan:
1. Reset/sequential: load mem[0..3]=0x20010001,0x20020002,0x20030003,0x20040004; release rst -> o_instruction follows that sequence on successive edges, with o_pc_plus4=4,8,12,16 and o_pc=4,8,12,16.
2. Stall: assert i_stall for 3 cycles while o_pc=8 -> o_pc=8, o_instruction=0x20020002 and o_pc_plus4=8 are held for all 3 cycles. Resume -> next is 0x20030003.
3. Redirect+flush: at pc=8, pulse i_pc_src=1, i_jump_addr=0x40, i_flush=1 -> next edge o_instruction=0, o_pc_plus4=0, o_pc=0x40. The following edge gives o_instruction=mem[16].
4. Stall priority: i_stall=1 with i_pc_src=1, i_jump_addr=0x80 -> o_pc is unchanged. Deassert the stall while holding i_pc_src -> o_pc=0x80.
5. Halt: mem[2]=0xFFFFFFFF -> after it is fetched, o_halt=1, o_pc=8 stays forever and i_pc_src is ignored. Async rst mid-cycle -> o_halt=0, o_pc=0 immediately.
6. Wrap/write: i_jump_addr=(MEM_DEPTH*4) -> fetches mem[0]. Writing mem[0] in the cycle it is fetched -> IF/ID captures the old value, and the next fetch of mem[0] returns the new value.
